// File: rtl/wb_queue.sv
// Write-back queue: merges never-stalled primary results with buffered secondary
// (valid/ready) results onto the single register-file write port.
// Optional feature: define WB_BYPASS_EN to write a secondary straight to the port when idle.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_we,
    input  logic [4:0]       p_addr,
    input  logic [31:0]      p_data,
    input  logic [31:0]      p_pc,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [4:0]       s_addr,
    input  logic [31:0]      s_data,
    input  logic [31:0]      s_pc,
    input  logic [4:0]       q_a1,
    input  logic [4:0]       q_a2,
    output logic             q_hit1,
    output logic             q_hit2,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [31:0]      wb_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [31:0]      wb_pc_q, wb_pc_d;

    logic s_acc;
    logic p_win;
    logic pop;
    logic push;
    logic bypass;

    always_comb begin
        s_ready = (count_q != FULL) && reset;
        s_acc   = s_valid && s_ready;
        p_win   = p_we && (p_addr != 5'd0);
        pop     = !p_win && (count_q != '0);
`ifdef WB_BYPASS_EN
        bypass  = s_acc && (s_addr != 5'd0) && (count_q == '0) && !p_win;
`else
        bypass  = 1'b0;
`endif
        push    = s_acc && (s_addr != 5'd0) && !bypass;
    end

    // Popped slots drop their valid bit so hit detection only ever sees occupied entries.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = s_addr;
            data_d[tail_q]  = s_data;
            pc_d[tail_q]    = s_pc;
        end
        // A winning primary write makes any older queued write to the same register dead.
        if (p_win) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_d[i] == p_addr) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_pc_d   = wb_pc_q;
        if (p_win) begin
            wb_we_d   = 1'b1;
            wb_addr_d = p_addr;
            wb_data_d = p_data;
            wb_pc_d   = p_pc;
        end else if (bypass) begin
            wb_we_d   = 1'b1;
            wb_addr_d = s_addr;
            wb_data_d = s_data;
            wb_pc_d   = s_pc;
        end else if (pop) begin
            wb_we_d   = valid_q[head_q];
            wb_addr_d = addr_q[head_q];
            wb_data_d = data_q[head_q];
            wb_pc_d   = pc_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_pc_q   <= wb_pc_d;
        end
    end

    always_comb begin
        q_hit1 = wb_we_q && (wb_addr_q == q_a1);
        q_hit2 = wb_we_q && (wb_addr_q == q_a2);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == q_a1)) q_hit1 = 1'b1;
            if (valid_q[i] && (addr_q[i] == q_a2)) q_hit2 = 1'b1;
        end
        if (q_a1 == 5'd0) q_hit1 = 1'b0;
        if (q_a2 == 5'd0) q_hit2 = 1'b0;
    end

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign wb_pc   = wb_pc_q;
    assign count   = count_q;

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue driving the register file's single write port. It merges single-cycle datapath results (primary, never stalled) with results from multi-cycle units such as mult/div (secondary, valid/ready handshake). Secondary results are buffered in a small FIFO and drained into idle write-port cycles. It also reports pending writes so the core can stall dependent reads.

## Interface

Parameters:
- DEPTH, 4, secondary FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (reset==0 clears state at posedge).
- p_we  in  1  primary write request.
- p_addr  in  5  primary destination register.
- p_data  in  32  primary write data.
- p_pc  in  32  PC of the primary instruction.
- s_valid  in  1  secondary result valid.
- s_ready  out  1  secondary result can be accepted.
- s_addr  in  5  secondary destination register.
- s_data  in  32  secondary write data.
- s_pc  in  32  PC of the secondary instruction.
- q_a1  in  5  query address 1 (rs).
- q_a2  in  5  query address 2 (rt).
- q_hit1  out  1  a write to q_a1 is pending.
- q_hit2  out  1  a write to q_a2 is pending.
- wb_we  out  1  register-file write enable (registered).
- wb_addr  out  5  register-file write address (registered).
- wb_data  out  32  register-file write data (registered).
- wb_pc  out  32  PC of the write, used for the register-file trace (registered).
- count  out  PTR_W+1  number of occupied FIFO entries, valid or squashed.

## Operation

- FIFO entries hold {valid, addr, data, pc}. Head and tail pointers are PTR_W bits and wrap modulo DEPTH.
- s_ready = (count != DEPTH) && reset. It is combinational from registered state and does not depend on s_valid or on a same-cycle dequeue.
- Secondary accept occurs when s_valid && s_ready at posedge.
  - s_addr==0: the result is accepted and discarded; it is not enqueued.
  - Otherwise it is enqueued at the tail with valid=1.
- Write-port arbitration at each posedge, in this priority order:
  1. p_we && p_addr!=0: wb_* loads the primary request and wb_we=1.
  2. Otherwise, if count>0: pop the head. wb_we takes the head's valid bit; wb_addr/data/pc take the head's fields.
  3. Otherwise: wb_we=0, and wb_addr/data/pc hold their previous values.
- p_we with p_addr==0 is a no-op; it frees the port for the FIFO.
- WAW squash: when the primary write wins (rule 1), every FIFO entry with addr==p_addr has its valid bit cleared at the same edge. This includes an entry enqueued at that same edge. Squashed entries still drain, taking one port cycle with wb_we=0.
- q_hitN = (q_aN!=0) && (any valid entry with addr==q_aN || (wb_we && wb_addr==q_aN)). It is combinational.
- Simultaneous enqueue and dequeue in one cycle leaves count unchanged.

## Timing

- Reset values: wb_we=0, wb_addr=0, wb_data=0, wb_pc=0, count=0, all valid bits 0, pointers 0. q_hit1=q_hit2=0 after the reset edge.
- Reset mid-operation discards all queued entries; none are written.
- Primary latency: a request in cycle N produces wb_we=1 in cycle N+1. The register file commits at the end of N+1.
- Secondary latency (macro off): accepted at edge E, earliest wb_we=1 in the cycle after edge E+1.
- Starvation: continuous p_we stalls the drain indefinitely. The FIFO fills and s_ready drops.
- Full: with count==DEPTH, s_ready=0 for the whole cycle, even if a pop occurs at the next edge.

## Configuration

- WB_BYPASS_EN defined: if count==0, the primary is idle (no p_we, or p_addr==0), and a secondary is accepted at edge E, then the secondary is loaded directly into wb_* at E without enqueueing. wb_we=1 in the cycle after E, and count stays 0.
- WB_BYPASS_EN undefined: every accepted secondary passes through the FIFO. Latency is as given in Timing.

## Test plan

- Reset: hold reset=0 for 2 cycles with p_we=1 and s_valid=1 → wb_we=0, count=0, s_ready=0. After release, s_ready=1.
- Primary path: p_we=1, p_addr=8, p_data=0x1234, p_pc=0x3000 in cycle N → cycle N+1 shows wb_we=1, wb_addr=8, wb_data=0x1234, wb_pc=0x3000.
- Fill/backpressure: with p_we held at 1, offer 5 secondaries (addrs 1..5) → 4 accepted, count=4, s_ready=0. Drop p_we → addrs 1,2,3,4 written in order on 4 consecutive cycles, then s_ready=1.
- WAW squash: enqueue s_addr=9, data=0xAAAA, then primary p_addr=9, data=0xBBBB → only 0xBBBB is written. The drained entry shows wb_we=0, and q_hit1 for q_a1=9 is 0 after that cycle.
- $0 and hits: s_addr=0 is accepted with count unchanged; p_addr=0 produces no write. With an entry pending for reg 17, q_a1=17 → q_hit1=1 and q_a2=0 → q_hit2=0.
- Bypass (WB_BYPASS_EN): empty FIFO, idle primary, s_valid with addr 3 at edge E → wb_we=1, wb_addr=3 in the cycle after E, count=0. Without the macro, the same stimulus gives the write one cycle later.
